// File: rtl/gaussian_pkg.sv
// Shared types and constants for the Gaussian window feeder.
package gaussian_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_LEN = 3;

  typedef enum logic [2:0] {
    IDLE,
    BURST0,
    BURST1,
    BURST2,
    WAIT_DONE
  } state_e;

  // One 3-row column: top = row r-2, mid = row r-1, bot = row r
  typedef struct packed {
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] mid;
    logic [DATA_W-1:0] bot;
  } column_t;

endpackage

// File: rtl/gaussian_window_feeder_if.sv
// Pixel-in / column-burst-out bus between source, feeder and Gaussian filter.
interface gaussian_window_feeder_if #(
  parameter int unsigned DATA_W = gaussian_pkg::DATA_W,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned ROW_W  = 9
);

  logic              pix_valid_i;
  logic [DATA_W-1:0] pix_i;
  logic              pix_ready_o;
  logic              en_o;
  logic [DATA_W-1:0] d1_o;
  logic [DATA_W-1:0] d2_o;
  logic [DATA_W-1:0] d3_o;
  logic              done_i;
  logic [ROW_W-1:0]  win_row_o;
  logic [COL_W-1:0]  win_col_o;
  logic              busy_o;

  // Feeder side
  modport master (
    input  pix_valid_i, pix_i, done_i,
    output pix_ready_o, en_o, d1_o, d2_o, d3_o, win_row_o, win_col_o, busy_o
  );

  // Source / filter side
  modport slave (
    output pix_valid_i, pix_i, done_i,
    input  pix_ready_o, en_o, d1_o, d2_o, d3_o, win_row_o, win_col_o, busy_o
  );

endinterface

// File: rtl/gaussian_line_buffer.sv
// Single-port line RAM: combinational read of the addressed entry, write on clock edge
// (so a same-cycle read returns the old contents).
module gaussian_line_buffer
  import gaussian_pkg::*;
#(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

  // Contents are never emitted before they have been written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/gaussian_window_feeder.sv
// Converts a raster pixel stream into 3-column bursts for the Gaussian filter,
// stalling the source until the filter reports done.
module gaussian_window_feeder
  import gaussian_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
  parameter int unsigned ROW_W      = $clog2(IMG_HEIGHT)
) (
  input logic                      clk,
  input logic                      rst_n,
  gaussian_window_feeder_if.master bus
);

  state_e            state, state_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [COL_W-1:0]  col, col_n;
  column_t           w0, w1, w2, w0_n, w1_n, w2_n;
  column_t           new_col_c;
  logic [DATA_W-1:0] line1_rd_c, line2_rd_c;
  logic              accept_c;

  column_t           d_q, d_n;
  logic              en_q, en_n;
  logic              ready_q, ready_n;
  logic              busy_q, busy_n;
  logic [ROW_W-1:0]  win_row_q, win_row_n;
  logic [COL_W-1:0]  win_col_q, win_col_n;

  assign accept_c  = bus.pix_valid_i && ready_q;
  assign new_col_c = '{top: line2_rd_c, mid: line1_rd_c, bot: bus.pix_i};

  gaussian_line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_line1 (
    .clk     (clk),
    .wr_en   (accept_c),
    .addr    (col),
    .wdata   (bus.pix_i),
    .rdata_c (line1_rd_c)
  );

  gaussian_line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_line2 (
    .clk     (clk),
    .wr_en   (accept_c),
    .addr    (col),
    .wdata   (line1_rd_c),
    .rdata_c (line2_rd_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, raster position, window shift and registered-output next values
  always_comb begin
    state_n   = state;
    row_n     = row;
    col_n     = col;
    w0_n      = w0;
    w1_n      = w1;
    w2_n      = w2;
    d_n       = d_q;
    win_row_n = win_row_q;
    win_col_n = win_col_q;

    case (state)
      IDLE: begin
        if (accept_c) begin
          w0_n = w1;
          w1_n = w2;
          w2_n = new_col_c;
          if (row >= ROW_W'(2) && col >= COL_W'(2)) begin
            state_n = BURST0;
          end
          if (col == COL_W'(IMG_WIDTH - 1)) begin
            col_n = '0;
            row_n = (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + ROW_W'(1);
          end else begin
            col_n = col + COL_W'(1);
          end
        end
      end
      BURST0:    state_n = BURST1;
      BURST1:    state_n = BURST2;
      BURST2:    state_n = WAIT_DONE;
      WAIT_DONE: if (bus.done_i) state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    // Outputs track the state being entered so they appear in that state's cycle
    case (state_n)
      BURST0: begin
        d_n       = w0_n;
        win_row_n = row - ROW_W'(1);
        win_col_n = col - COL_W'(1);
      end
      BURST1:  d_n = w1_n;
      BURST2:  d_n = w2_n;
      default: d_n = d_q;
    endcase

    en_n    = (state_n == BURST0);
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      d_q       <= '0;
      en_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      row       <= row_n;
      col       <= col_n;
      w0        <= w0_n;
      w1        <= w1_n;
      w2        <= w2_n;
      d_q       <= d_n;
      en_q      <= en_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      win_row_q <= win_row_n;
      win_col_q <= win_col_n;
    end
  end

  assign bus.pix_ready_o = ready_q;
  assign bus.en_o        = en_q;
  assign bus.d1_o        = d_q.top;
  assign bus.d2_o        = d_q.mid;
  assign bus.d3_o        = d_q.bot;
  assign bus.win_row_o   = win_row_q;
  assign bus.win_col_o   = win_col_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_gaussian_window_feeder.sv
// Bench for gaussian_window_feeder on a 4x4 image: directed raster frames, reset
// mid-burst, then random pixels/gaps/done timing against an image-array model.
module tb_gaussian_window_feeder;
  import gaussian_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gaussian_window_feeder_if #(.DATA_W(DATA_W), .COL_W(CW), .ROW_W(RW)) bus ();

  gaussian_window_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (CW),
    .ROW_W     (RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: the frame seen so far plus the raster position of the next pixel
  logic [DATA_W-1:0] img [H][W];
  int mr = 0;
  int mc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected column k of the window whose bottom row is r
  task automatic check_col(input string tag, input int r, input int k);
    check({tag, "_d1"}, 32'(bus.d1_o), 32'(img[r-2][k]));
    check({tag, "_d2"}, 32'(bus.d2_o), 32'(img[r-1][k]));
    check({tag, "_d3"}, 32'(bus.d3_o), 32'(img[r][k]));
  endtask

  // Offer one pixel; if it launches a window, check the burst and answer done
  // after dly WAIT_DONE cycles (or hold done high from the burst start if early).
  task automatic push(input logic [DATA_W-1:0] v, input int dly, input bit early);
    int guard;
    int r;
    int c;
    bit launch;
    guard = 0;
    while (bus.pix_ready_o !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    check("ready_wait", 32'(guard < 100), 32'(1));
    bus.pix_valid_i = 1'b1;
    bus.pix_i       = v;
    r = mr;
    c = mc;
    img[r][c] = v;
    launch = (r >= 2) && (c >= 2);
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
    step();
    bus.pix_valid_i = 1'b0;
    bus.pix_i       = DATA_W'($urandom);
    if (!launch) begin
      check("idle_en", 32'(bus.en_o), 32'(0));
      check("idle_ready", 32'(bus.pix_ready_o), 32'(1));
      check("idle_busy", 32'(bus.busy_o), 32'(0));
    end else begin
      if (early) bus.done_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
        check("burst_en", 32'(bus.en_o), 32'(k == 0));
        check_col("burst", r, c - 2 + k);
        check("burst_ready", 32'(bus.pix_ready_o), 32'(0));
        check("burst_busy", 32'(bus.busy_o), 32'(1));
        if (k == 0) begin
          check("win_row", 32'(bus.win_row_o), 32'(r - 1));
          check("win_col", 32'(bus.win_col_o), 32'(c - 1));
        end
        step();
      end
      for (int i = 0; i < (early ? 0 : dly); i++) begin
        check("wait_en", 32'(bus.en_o), 32'(0));
        check("wait_ready", 32'(bus.pix_ready_o), 32'(0));
        check_col("wait_hold", r, c);
        step();
      end
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check("done_ready", 32'(bus.pix_ready_o), 32'(1));
      check("done_busy", 32'(bus.busy_o), 32'(0));
      check("done_en", 32'(bus.en_o), 32'(0));
      check_col("idle_hold", r, c);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.pix_ready_o), 32'(0));
    check({tag, "_en"}, 32'(bus.en_o), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy_o), 32'(0));
    check({tag, "_d"}, {8'h0, bus.d1_o, bus.d2_o, bus.d3_o}, 32'(0));
    check({tag, "_win"}, 32'({bus.win_row_o, bus.win_col_o}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid_i = 1'b0;
    bus.pix_i       = '0;
    bus.done_i      = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("ready_after_reset", 32'(bus.pix_ready_o), 32'(1));

    // Frame 1: raster index 1..16, long done hold on the first window
    for (int v = 1; v <= 16; v++) push(DATA_W'(v), (v == 11) ? 20 : 1, 1'b0);
    // Frame 2: same content, row counter has wrapped
    for (int v = 1; v <= 16; v++) push(DATA_W'(v), 1, 1'b0);

    // Reset during BURST1, then replay the start of the frame
    for (int v = 1; v <= 10; v++) push(DATA_W'(v), 1, 1'b0);
    bus.pix_valid_i = 1'b1;
    bus.pix_i       = DATA_W'(11);
    step();
    bus.pix_valid_i = 1'b0;
    check("rst_test_en", 32'(bus.en_o), 32'(1));
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    step();
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
    step();
    check("ready_after_mid_reset", 32'(bus.pix_ready_o), 32'(1));
    for (int v = 1; v <= 16; v++) push(DATA_W'(v), 1, 1'b0);

    // Random pixels, gaps with stray done pulses, random done timing
    for (int i = 0; i < 48; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.done_i = 1'($urandom_range(0, 1));
        step();
      end
      bus.done_i = 1'b0;
      push(DATA_W'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
